jtag_tap_regs: RTL and testbench
================================

Name: jtag_tap_regs

Overview:
- Downstream consumer of the TAP state machine: the IEEE 1149.1-style instruction register plus data-register bank.
- Each cycle, acts on the 4-bit TAP state code to capture, shift, or update the instruction register (IR) and the selected data register (DR).
- Drives TDO and exposes the decoded instruction and a user data register to the core.

Parameters:
- IR_W, 4, instruction register width (>=2).
- DR_W, 8, user data register width.
- IDCODE_VAL, 32'h1234_5001, device ID captured by IDCODE; bit0 must be 1.
- IDCODE_OP, 4'h1, IDCODE opcode; also the reset value of IR.
- USER_OP, 4'h2, opcode selecting the user DR.
- BYPASS_OP, all ones, BYPASS opcode.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- TRST  in  1  synchronous active-high reset.
- tap_state  in  4  current TAP state code (shared 16-state encoding: Test_logic_Reset=0 … Update_IR=15).
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- TDO_en  out  1  high while in Shift_IR or Shift_DR.
- ir_out  out  IR_W  active instruction.
- user_capture_in  in  DR_W  parallel value loaded into the user shift register at Capture_DR.
- user_dr_out  out  DR_W  user register parallel output.
- user_update  out  1  one-cycle pulse when user_dr_out is written.

Behaviour:
- Synchronous reset (TRST=1 at an edge) sets:
  - ir_out=IDCODE_OP.
  - ir_shift=0, bypass_bit=0, idcode_shift=0, user_shift=0.
  - user_dr_out=0, user_update=0.
  - TRST has priority over every tap_state action, including mid-shift.
- tap_state=Test_logic_Reset (no TRST): same effect as TRST.
- Capture_IR: ir_shift <= {(IR_W-2){0}, 2'b01}.
- Shift_IR: ir_shift <= {TDI, ir_shift[IR_W-1:1]}, LSB out first.
- Update_IR: ir_out <= ir_shift. ir_out changes only here or on reset.
- DR selection by ir_out:
  - IDCODE_OP → 32-bit idcode_shift.
  - USER_OP → DR_W-bit user_shift.
  - BYPASS_OP or any undefined opcode → 1-bit bypass_bit.
- Capture_DR:
  - Selected register loads: bypass_bit<=0, idcode_shift<=IDCODE_VAL, or user_shift<=user_capture_in.
  - Unselected registers hold.
- Shift_DR: selected register shifts right, TDI into MSB. Bypass: bypass_bit<=TDI.
- Update_DR:
  - USER selected: user_dr_out<=user_shift and user_update=1 for exactly this one cycle.
  - Other selections: no effect.
- All other states (Run_Test_Idle, Select_*, Exit1/2_*, Pause_*): every register holds; user_update=0.
- TDO is combinational from registers only; no combinational TDI→TDO path.
  - Shift_IR: ir_shift[0].
  - Shift_DR: bit0 of the selected register (bypass_bit for bypass).
  - Otherwise 0.
- TDO_en = (tap_state==Shift_IR)||(tap_state==Shift_DR).
- Latency: one TDI bit appears on TDO after IR_W, 32, DR_W, or 1 shift cycles respectively.
- Pause/Exit mid-shift preserves partial contents; shifting resumes exactly where it stopped.

Decomposition:
- Package jtag_pkg holds:
  - The 16 TAP state code constants, shared with the TAP controller.
  - Default opcode constants.
- Sub-module jtag_shift_reg (param WIDTH):
  - Inputs: capture, shift, capture value, TDI.
  - Outputs: parallel contents, serial LSB.
  - Instantiated for the IR, IDCODE, and user registers.

Test Plan:
1. TRST pulse, then Capture_DR + 32×Shift_DR with TDI=0 → TDO LSB-first = 32'h1234_5001; ir_out=4'h1 throughout.
2. Capture_IR, then 4×Shift_IR with TDI=0,1,0,0, then Update_IR → TDO=1,0,0,0, TDO_en=1 only during shifts, ir_out=4'h2 after update.
3. ir=USER, user_capture_in=8'hA5, Capture_DR + 8×Shift_DR with TDI=8'h3C LSB-first, then Update_DR → TDO=8'hA5 LSB-first; user_dr_out=8'h3C; user_update high exactly one cycle.
4. ir=4'hF, then ir=4'h7: Capture_DR, Shift_DR with TDI=1,0,1,1 → TDO=0,1,0,1 in both cases; Update_DR leaves user_dr_out unchanged, no user_update.
5. USER shift of 4 bits, 3 cycles Pause_DR, Exit2_DR, then 4 more Shift_DR → same TDO stream and final user_dr_out as an uninterrupted 8-bit shift.
6. TRST asserted mid Shift_DR with user_dr_out=8'h3C, and separately tap_state=Test_logic_Reset → next edge: ir_out=4'h1, user_dr_out=0, TDO=0, user_update=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// ============================================================================
// Module   : jtag_pkg
// Purpose  : TAP state codes shared with the TAP controller, default opcodes
// Revision : 1.0
// ============================================================================
`default_nettype none

package jtag_pkg;

    localparam logic [3:0] c_TAP_TEST_LOGIC_RESET = 4'd0;
    localparam logic [3:0] c_TAP_RUN_TEST_IDLE    = 4'd1;
    localparam logic [3:0] c_TAP_SELECT_DR        = 4'd2;
    localparam logic [3:0] c_TAP_CAPTURE_DR       = 4'd3;
    localparam logic [3:0] c_TAP_SHIFT_DR         = 4'd4;
    localparam logic [3:0] c_TAP_EXIT1_DR         = 4'd5;
    localparam logic [3:0] c_TAP_PAUSE_DR         = 4'd6;
    localparam logic [3:0] c_TAP_EXIT2_DR         = 4'd7;
    localparam logic [3:0] c_TAP_UPDATE_DR        = 4'd8;
    localparam logic [3:0] c_TAP_SELECT_IR        = 4'd9;
    localparam logic [3:0] c_TAP_CAPTURE_IR       = 4'd10;
    localparam logic [3:0] c_TAP_SHIFT_IR         = 4'd11;
    localparam logic [3:0] c_TAP_EXIT1_IR         = 4'd12;
    localparam logic [3:0] c_TAP_PAUSE_IR         = 4'd13;
    localparam logic [3:0] c_TAP_EXIT2_IR         = 4'd14;
    localparam logic [3:0] c_TAP_UPDATE_IR        = 4'd15;

    localparam logic [3:0]  c_IDCODE_OP_DEF  = 4'h1;
    localparam logic [3:0]  c_USER_OP_DEF    = 4'h2;
    localparam logic [31:0] c_IDCODE_VAL_DEF = 32'h1234_5001;

endpackage

`default_nettype wire

// File: rtl/jtag_shift_reg.sv
// ============================================================================
// Module   : jtag_shift_reg
// Purpose  : Capture/shift register, TDI enters at MSB, LSB is the serial out
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_cap_val,
    input  logic             i_tdi,
    output logic [WIDTH-1:0] o_q,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = i_tdi;
        end else begin : g_multi
            assign w_shifted = {i_tdi, r_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_capture) begin
            r_q <= i_cap_val;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end
    end

    assign o_q   = r_q;
    assign o_lsb = r_q[0];

endmodule

`default_nettype wire

// File: rtl/jtag_tap_regs.sv
// ============================================================================
// Module   : jtag_tap_regs
// Purpose  : JTAG instruction register and data-register bank driven by the
//            TAP state code; produces TDO and the user register outputs
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_tap_regs
    import jtag_pkg::*;
#(
    parameter int              IR_W       = 4,
    parameter int              DR_W       = 8,
    parameter logic [31:0]     IDCODE_VAL = c_IDCODE_VAL_DEF,
    parameter logic [IR_W-1:0] IDCODE_OP  = IR_W'(c_IDCODE_OP_DEF),
    parameter logic [IR_W-1:0] USER_OP    = IR_W'(c_USER_OP_DEF),
    parameter logic [IR_W-1:0] BYPASS_OP  = '1
) (
    input  logic            clk,
    input  logic            TRST,
    input  logic [3:0]      tap_state,
    input  logic            TDI,
    output logic            TDO,
    output logic            TDO_en,
    output logic [IR_W-1:0] ir_out,
    input  logic [DR_W-1:0] user_capture_in,
    output logic [DR_W-1:0] user_dr_out,
    output logic            user_update
);

    logic            w_rst;
    logic            w_cap_ir, w_sh_ir, w_upd_ir;
    logic            w_cap_dr, w_sh_dr, w_upd_dr;
    logic            w_sel_idcode, w_sel_user, w_sel_bypass;
    logic [IR_W-1:0] w_ir_shift;
    logic            w_ir_lsb;
    logic [31:0]     w_unused_idcode_q;
    logic            w_idcode_lsb;
    logic [DR_W-1:0] w_user_q;
    logic            w_user_lsb;
    logic            w_tdo;

    logic [IR_W-1:0] r_ir;
    logic            r_bypass;
    logic [DR_W-1:0] r_user_dr;
    logic            r_user_update;

    // Test_Logic_Reset behaves exactly like TRST
    assign w_rst    = TRST || (tap_state == c_TAP_TEST_LOGIC_RESET);

    assign w_cap_ir = (tap_state == c_TAP_CAPTURE_IR);
    assign w_sh_ir  = (tap_state == c_TAP_SHIFT_IR);
    assign w_upd_ir = (tap_state == c_TAP_UPDATE_IR);
    assign w_cap_dr = (tap_state == c_TAP_CAPTURE_DR);
    assign w_sh_dr  = (tap_state == c_TAP_SHIFT_DR);
    assign w_upd_dr = (tap_state == c_TAP_UPDATE_DR);

    // An explicit BYPASS opcode always wins; anything unrecognised falls to bypass
    assign w_sel_idcode = (r_ir == IDCODE_OP) && (r_ir != BYPASS_OP);
    assign w_sel_user   = (r_ir == USER_OP) && (r_ir != BYPASS_OP) && !w_sel_idcode;
    assign w_sel_bypass = !w_sel_idcode && !w_sel_user;

    jtag_shift_reg #(
        .WIDTH (IR_W)
    ) u_ir_shift (
        .clk       (clk),
        .rst       (w_rst),
        .i_capture (w_cap_ir),
        .i_shift   (w_sh_ir),
        .i_cap_val (IR_W'(2'b01)),
        .i_tdi     (TDI),
        .o_q       (w_ir_shift),
        .o_lsb     (w_ir_lsb)
    );

    jtag_shift_reg #(
        .WIDTH (32)
    ) u_idcode_shift (
        .clk       (clk),
        .rst       (w_rst),
        .i_capture (w_cap_dr && w_sel_idcode),
        .i_shift   (w_sh_dr && w_sel_idcode),
        .i_cap_val (IDCODE_VAL),
        .i_tdi     (TDI),
        .o_q       (w_unused_idcode_q),
        .o_lsb     (w_idcode_lsb)
    );

    jtag_shift_reg #(
        .WIDTH (DR_W)
    ) u_user_shift (
        .clk       (clk),
        .rst       (w_rst),
        .i_capture (w_cap_dr && w_sel_user),
        .i_shift   (w_sh_dr && w_sel_user),
        .i_cap_val (user_capture_in),
        .i_tdi     (TDI),
        .o_q       (w_user_q),
        .o_lsb     (w_user_lsb)
    );

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_ir <= IDCODE_OP;
        end else if (w_upd_ir) begin
            r_ir <= w_ir_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_bypass <= 1'b0;
        end else if (w_cap_dr && w_sel_bypass) begin
            r_bypass <= 1'b0;
        end else if (w_sh_dr && w_sel_bypass) begin
            r_bypass <= TDI;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_user_dr     <= '0;
            r_user_update <= 1'b0;
        end else begin
            r_user_update <= w_upd_dr && w_sel_user;
            if (w_upd_dr && w_sel_user) begin
                r_user_dr <= w_user_q;
            end
        end
    end

    // TDO is taken from register bits only, never straight from TDI
    always_comb begin
        w_tdo = 1'b0;
        if (w_sh_ir) begin
            w_tdo = w_ir_lsb;
        end else if (w_sh_dr) begin
            if (w_sel_idcode) begin
                w_tdo = w_idcode_lsb;
            end else if (w_sel_user) begin
                w_tdo = w_user_lsb;
            end else begin
                w_tdo = r_bypass;
            end
        end
    end

    assign TDO         = w_tdo;
    assign TDO_en      = w_sh_ir || w_sh_dr;
    assign ir_out      = r_ir;
    assign user_dr_out = r_user_dr;
    assign user_update = r_user_update;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_regs.sv
// ============================================================================
// Module   : tb_jtag_tap_regs
// Purpose  : Directed self-checking bench for jtag_tap_regs
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jtag_tap_regs;
    import jtag_pkg::*;

    logic       clk;
    logic       TRST;
    logic [3:0] tap_state;
    logic       TDI;
    logic       TDO;
    logic       TDO_en;
    logic [3:0] ir_out;
    logic [7:0] user_capture_in;
    logic [7:0] user_dr_out;
    logic       user_update;

    int total = 0;
    int bad   = 0;

    jtag_tap_regs dut (
        .clk             (clk),
        .TRST            (TRST),
        .tap_state       (tap_state),
        .TDI             (TDI),
        .TDO             (TDO),
        .TDO_en          (TDO_en),
        .ir_out          (ir_out),
        .user_capture_in (user_capture_in),
        .user_dr_out     (user_dr_out),
        .user_update     (user_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] st);
        tap_state = st;
        tick();
    endtask

    // Shifts n bits of din LSB-first; records TDO and TDO_en seen before each edge
    task automatic shift_bits(input logic [3:0] st, input int n, input logic [31:0] din,
                              output logic [31:0] dout, output logic [31:0] en);
        dout = '0;
        en   = '0;
        for (int i = 0; i < n; i++) begin
            tap_state = st;
            TDI       = din[i];
            #1;
            dout[i] = TDO;
            en[i]   = TDO_en;
            tick();
        end
        TDI = 1'b0;
    endtask

    task automatic load_ir(input logic [3:0] op);
        logic [31:0] d, e;
        go(c_TAP_CAPTURE_IR);
        shift_bits(c_TAP_SHIFT_IR, 4, {28'd0, op}, d, e);
        go(c_TAP_EXIT1_IR);
        go(c_TAP_UPDATE_IR);
        go(c_TAP_RUN_TEST_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, e, d2;

        TRST            = 1'b1;
        tap_state       = c_TAP_RUN_TEST_IDLE;
        TDI             = 1'b0;
        user_capture_in = 8'h00;
        tick();
        TRST = 1'b0;
        #1;
        chk("rst_ir",     {28'd0, ir_out}, 32'h1);
        chk("rst_udr",    {24'd0, user_dr_out}, 32'h0);
        chk("rst_upd",    {31'd0, user_update}, 32'h0);
        chk("rst_tdo",    {31'd0, TDO}, 32'h0);
        chk("rst_tdo_en", {31'd0, TDO_en}, 32'h0);

        // 1: IDCODE readout
        go(c_TAP_SELECT_DR);
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 32, 32'h0, d, e);
        chk("t1_idcode", d, 32'h1234_5001);
        chk("t1_en",     e, 32'hFFFF_FFFF);
        chk("t1_ir",     {28'd0, ir_out}, 32'h1);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        chk("t1_noupd",  {31'd0, user_update}, 32'h0);
        go(c_TAP_RUN_TEST_IDLE);

        // 2: IR load of USER opcode
        go(c_TAP_SELECT_IR);
        go(c_TAP_CAPTURE_IR);
        chk("t2_en_cap", {31'd0, TDO_en}, 32'h0);
        shift_bits(c_TAP_SHIFT_IR, 4, 32'h2, d, e);
        chk("t2_tdo", d, 32'h1);
        chk("t2_en",  e, 32'hF);
        tap_state = c_TAP_EXIT1_IR;
        #1;
        chk("t2_en_exit", {31'd0, TDO_en}, 32'h0);
        tick();
        chk("t2_ir_pre", {28'd0, ir_out}, 32'h1);
        go(c_TAP_UPDATE_IR);
        chk("t2_ir_post", {28'd0, ir_out}, 32'h2);
        go(c_TAP_RUN_TEST_IDLE);

        // 3: user register transfer
        user_capture_in = 8'hA5;
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 8, 32'h3C, d, e);
        chk("t3_tdo", d, 32'hA5);
        go(c_TAP_EXIT1_DR);
        chk("t3_upd_pre", {31'd0, user_update}, 32'h0);
        chk("t3_udr_pre", {24'd0, user_dr_out}, 32'h0);
        go(c_TAP_UPDATE_DR);
        chk("t3_udr", {24'd0, user_dr_out}, 32'h3C);
        chk("t3_upd", {31'd0, user_update}, 32'h1);
        go(c_TAP_RUN_TEST_IDLE);
        chk("t3_upd_off", {31'd0, user_update}, 32'h0);

        // 4: explicit BYPASS and an undefined opcode
        load_ir(4'hF);
        chk("t4_ir_f", {28'd0, ir_out}, 32'hF);
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 4, 32'hD, d, e);
        chk("t4_byp_f", d, 32'hA);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        chk("t4_udr_f", {24'd0, user_dr_out}, 32'h3C);
        chk("t4_upd_f", {31'd0, user_update}, 32'h0);
        go(c_TAP_RUN_TEST_IDLE);
        load_ir(4'h7);
        chk("t4_ir_7", {28'd0, ir_out}, 32'h7);
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 4, 32'hD, d, e);
        chk("t4_byp_7", d, 32'hA);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        chk("t4_udr_7", {24'd0, user_dr_out}, 32'h3C);
        chk("t4_upd_7", {31'd0, user_update}, 32'h0);
        go(c_TAP_RUN_TEST_IDLE);

        // 5: user shift interrupted by pause
        load_ir(4'h2);
        user_capture_in = 8'h5A;
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 4, 32'h6, d, e);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_PAUSE_DR);
        chk("t5_pause_tdo", {31'd0, TDO}, 32'h0);
        chk("t5_pause_en",  {31'd0, TDO_en}, 32'h0);
        go(c_TAP_PAUSE_DR);
        go(c_TAP_PAUSE_DR);
        go(c_TAP_EXIT2_DR);
        shift_bits(c_TAP_SHIFT_DR, 4, 32'h9, d2, e);
        chk("t5_tdo", {24'd0, d2[3:0], d[3:0]}, 32'h5A);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        chk("t5_udr", {24'd0, user_dr_out}, 32'h96);
        chk("t5_upd", {31'd0, user_update}, 32'h1);
        go(c_TAP_RUN_TEST_IDLE);

        // 6a: TRST in the middle of a user shift
        user_capture_in = 8'hA5;
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 8, 32'h3C, d, e);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        go(c_TAP_RUN_TEST_IDLE);
        chk("t6_udr_set", {24'd0, user_dr_out}, 32'h3C);
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 3, 32'h7, d, e);
        tap_state = c_TAP_SHIFT_DR;
        TRST      = 1'b1;
        tick();
        TRST = 1'b0;
        #1;
        chk("t6a_ir",  {28'd0, ir_out}, 32'h1);
        chk("t6a_udr", {24'd0, user_dr_out}, 32'h0);
        chk("t6a_tdo", {31'd0, TDO}, 32'h0);
        chk("t6a_upd", {31'd0, user_update}, 32'h0);
        go(c_TAP_RUN_TEST_IDLE);

        // 6b: Test_Logic_Reset state right after an update pulse
        load_ir(4'h2);
        go(c_TAP_CAPTURE_DR);
        shift_bits(c_TAP_SHIFT_DR, 8, 32'h3C, d, e);
        go(c_TAP_EXIT1_DR);
        go(c_TAP_UPDATE_DR);
        chk("t6b_upd_set", {31'd0, user_update}, 32'h1);
        go(c_TAP_TEST_LOGIC_RESET);
        chk("t6b_ir",  {28'd0, ir_out}, 32'h1);
        chk("t6b_udr", {24'd0, user_dr_out}, 32'h0);
        chk("t6b_upd", {31'd0, user_update}, 32'h0);
        chk("t6b_tdo", {31'd0, TDO}, 32'h0);
        tap_state = c_TAP_SHIFT_DR;
        #1;
        chk("t6b_tdo_sh", {31'd0, TDO}, 32'h0);
        go(c_TAP_RUN_TEST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
